// File: rtl/param_stack.sv
// param_stack -- parametrised LIFO stack for the stack-computer datapath.
//
// Build option: define STACK_DUP_EN to add the 'dup' input, which copies the
// current top entry onto the stack when neither push nor pop is requested.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset (highest priority)
//   push       push request
//   pop        pop request (push+pop together = replace-top)
//   clr_err    clears the sticky overflow/underflow flags
//   dup        (STACK_DUP_EN only) duplicate top entry
//   din        data to push
//   dout       registered value of the last successful pop / replace-top
//   top_data   peek of the current top entry, 0 when empty
//   count      number of valid entries, 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
//   overflow   sticky: push (or dup) attempted while full
//   underflow  sticky: pop (or dup) attempted while empty
//
// There is no valid/ready handshake: every request is acted on in the cycle
// it is sampled, and illegal requests are recorded in the sticky flags
// instead of being back-pressured.
module param_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clr_err,
`ifdef STACK_DUP_EN
  input  logic                         dup,
`endif
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic [WIDTH-1:0]             top_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic           dup_req;
  logic [AW-1:0]  wr_idx;   // slot above the top (sp)
  logic [AW-1:0]  top_idx;  // current top (sp-1)
  logic [WIDTH-1:0] top_word;

  // Decoded operations for this cycle.
  logic do_push;    // plain push into a non-full stack
  logic do_pop;     // plain pop from a non-empty stack
  logic do_repl;    // replace-top on a non-empty stack
  logic push_empty; // push+pop on an empty stack: behaves as a push
  logic do_dup;     // duplicate top onto a partially filled stack
  logic ov_evt;
  logic un_evt;

  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wdata;

`ifdef STACK_DUP_EN
  assign dup_req = dup;
`else
  assign dup_req = 1'b0;
`endif

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign wr_idx   = AW'(count);
  assign top_idx  = AW'(count - CW'(1));
  assign top_word = mem[top_idx];
  // Memory is not reset, so the peek must be masked while empty.
  assign top_data = empty ? '0 : top_word;

  always_comb begin
    do_push    = push & ~pop & ~full;
    do_pop     = pop & ~push & ~empty;
    do_repl    = push & pop & ~empty;
    push_empty = push & pop & empty;
    // dup is only honoured when the stack is otherwise idle.
    do_dup     = dup_req & ~push & ~pop & ~empty & ~full;
    ov_evt     = (push & ~pop & full) | (dup_req & ~push & ~pop & full);
    un_evt     = (pop & empty) | (dup_req & ~push & ~pop & empty);
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = wr_idx;
    mem_wdata = din;
    if (do_push || push_empty) begin
      mem_we = 1'b1;
    end else if (do_repl) begin
      mem_we   = 1'b1;
      mem_addr = top_idx;
    end else if (do_dup) begin
      mem_we    = 1'b1;
      mem_wdata = top_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      dout      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_push || push_empty || do_dup) begin
        count <= count + CW'(1);
      end else if (do_pop) begin
        count <= count - CW'(1);
      end
      if (do_pop || do_repl) begin
        dout <= top_word;
      end
      // A new error event in the same cycle as clr_err keeps the flag set.
      overflow  <= (overflow  & ~clr_err) | ov_evt;
      underflow <= (underflow & ~clr_err) | un_evt;
    end
  end

endmodule

// File: tb/tb_param_stack.sv
module tb_param_stack;

  localparam int W  = 8;
  localparam int D  = 8;
  localparam int CW = $clog2(D+1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset   = 1'b1;
  logic          push    = 1'b0;
  logic          pop     = 1'b0;
  logic          clr_err = 1'b0;
  logic          dup     = 1'b0;
  logic [W-1:0]  din     = '0;
  logic [W-1:0]  dout;
  logic [W-1:0]  top_data;
  logic [CW-1:0] count;
  logic          full, empty, overflow, underflow;

  param_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .clr_err   (clr_err),
`ifdef STACK_DUP_EN
    .dup       (dup),
`endif
    .din       (din),
    .dout      (dout),
    .top_data  (top_data),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // ---------------- reference model ----------------
  logic [W-1:0] exp_q[$];   // stack contents, back = top
  logic [W-1:0] m_dout;
  logic         m_ov, m_un;

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic p, input logic po,
                            input logic c, input logic du, input logic [W-1:0] d);
    logic ov_e, un_e;
    ov_e = 1'b0;
    un_e = 1'b0;
    if (r) begin
      exp_q.delete();
      m_dout = '0;
      m_ov   = 1'b0;
      m_un   = 1'b0;
    end else begin
      if (p && po) begin
        if (exp_q.size() == 0) begin
          exp_q.push_back(d);
          un_e = 1'b1;
        end else begin
          m_dout = exp_q[$];
          exp_q[$] = d;
        end
      end else if (p) begin
        if (exp_q.size() == D) ov_e = 1'b1;
        else exp_q.push_back(d);
      end else if (po) begin
        if (exp_q.size() == 0) un_e = 1'b1;
        else m_dout = exp_q.pop_back();
      end else if (du) begin
`ifdef STACK_DUP_EN
        if (exp_q.size() == 0) un_e = 1'b1;
        else if (exp_q.size() == D) ov_e = 1'b1;
        else exp_q.push_back(exp_q[$]);
`endif
      end
      if (c) begin
        m_ov = 1'b0;
        m_un = 1'b0;
      end
      m_ov = m_ov | ov_e;
      m_un = m_un | un_e;
    end
  endtask

  task automatic compare_all(input string tag);
    int n;
    logic [W-1:0] t;
    n = exp_q.size();
    t = (n == 0) ? '0 : exp_q[$];
    check_val({tag, "_count"},     32'(count),     32'(n));
    check_val({tag, "_top"},       32'(top_data),  32'(t));
    check_val({tag, "_dout"},      32'(dout),      32'(m_dout));
    check_val({tag, "_full"},      32'(full),      32'(n == D));
    check_val({tag, "_empty"},     32'(empty),     32'(n == 0));
    check_val({tag, "_overflow"},  32'(overflow),  32'(m_ov));
    check_val({tag, "_underflow"}, 32'(underflow), 32'(m_un));
  endtask

  // ---------------- driver ----------------
  // Drive one cycle: inputs applied away from the edge, model updated at the
  // edge, outputs compared 1 time unit after it.
  task automatic step(input string tag, input logic r, input logic p, input logic po,
                      input logic c, input logic du, input logic [W-1:0] d);
    reset = r; push = p; pop = po; clr_err = c; dup = du; din = d;
    @(posedge clk);
    model_step(r, p, po, c, du, d);
    #1;
    compare_all(tag);
    reset = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0; dup = 1'b0;
  endtask

  task automatic do_push(input string tag, input logic [W-1:0] d);
    step(tag, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, d);
  endtask

  task automatic do_pop(input string tag);
    step(tag, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset(input string tag);
    step(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_dout = '0; m_ov = 1'b0; m_un = 1'b0;
    #2;
    do_reset("rst");
    do_reset("rst2");

    // 1: push three, pop three
    do_push("t1_push", 8'h11);
    do_push("t1_push", 8'h22);
    do_push("t1_push", 8'h33);
    check_val("t1_top_const", 32'(top_data), 32'h33);
    do_pop("t1_pop");
    check_val("t1_dout_33", 32'(dout), 32'h33);
    do_pop("t1_pop");
    check_val("t1_dout_22", 32'(dout), 32'h22);
    do_pop("t1_pop");
    check_val("t1_dout_11", 32'(dout), 32'h11);

    // 2: fill, overflow, pop, clear
    for (int i = 1; i <= D; i++) do_push("t2_fill", W'(i));
    do_push("t2_ovf", 8'hFF);
    check_val("t2_ovf_const", 32'(overflow), 32'd1);
    do_pop("t2_pop");
    step("t2_clr", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    check_val("t2_clr_const", 32'(overflow), 32'd0);

    // 3: underflow on empty, push+pop on empty
    do_reset("t3_rst");
    do_pop("t3_unf");
    step("t3_pp_empty", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A);
    check_val("t3_dout_const", 32'(dout), 32'h0);

    // 4: replace-top, also when full
    do_reset("t4_rst");
    do_push("t4_push", 8'h10);
    do_push("t4_push", 8'h20);
    step("t4_repl", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h99);
    check_val("t4_dout_const", 32'(dout), 32'h20);
    for (int i = 0; i < D-2; i++) do_push("t4_fill", 8'hA0 + W'(i));
    step("t4_repl_full", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hC3);

    // clr_err together with a new error event: flag stays set
    step("t4_clr_and_ovf", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hEE);

    // 5: reset wins over a same-cycle push
    do_reset("t5_rst");
    do_push("t5_push", 8'h44);
    do_push("t5_push", 8'h55);
    step("t5_rst_push", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h66);
    do_push("t5_after", 8'h77);

`ifdef STACK_DUP_EN
    // 6: dup behaviour
    do_reset("t6_rst");
    step("t6_dup_empty", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    do_push("t6_push", 8'h3C);
    step("t6_dup", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    step("t6_dup_push", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01);
    for (int i = 0; i < D; i++) step("t6_dup_fill", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
`endif

    // Random traffic
    do_reset("rnd_rst");
    for (int i = 0; i < 3000; i++) begin
      int   r;
      logic rr, pp, po, cc, du;
      r  = int'($urandom_range(0, 99));
      rr = (r < 1);
      pp = ($urandom_range(0, 99) < 50);
      po = ($urandom_range(0, 99) < 40);
      cc = ($urandom_range(0, 99) < 6);
      du = ($urandom_range(0, 99) < 15);
      step("rnd", rr, pp, po, cc, du, W'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
